// File: rtl/key_overlay.sv
// rtl/key_overlay.sv - piano keyboard overlay: key fills, separators, divider, press highlight and fade
module key_overlay #(
    parameter int NUM_KEYS    = 40,
    parameter int KEY_W_LOG2  = 4,
    parameter int KEY_TOP     = 320,
    parameter int LINE_W      = 2,
    parameter int HOLD_FRAMES = 8,
    parameter int CW          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [NUM_KEYS-1:0] key_down,
    input  logic                in_valid,
    input  logic [CW-1:0]       in_x,
    input  logic [CW-1:0]       in_y,
    input  logic [8:0]          in_color,
    input  logic                in_finger,
    output logic                out_valid,
    output logic [8:0]          out_color
);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam int KID_W = CW - KEY_W_LOG2;

    logic [NUM_KEYS-1:0] pressed;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
        end else if (frame_start) begin
            pressed <= key_down;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_down[k])
                    cnt[k] <= CNT_W'(HOLD_FRAMES);
                else if (cnt[k] != '0)
                    cnt[k] <= cnt[k] - 1'b1;
            end
        end
    end

    logic [KID_W-1:0] key_id;
    logic             sel_pressed;
    logic             sel_fading;
    logic             is_key;
    logic             is_div;
    logic             is_vline;
    logic [8:0]       base;
    logic [8:0]       filter;

    assign key_id = in_x[CW-1:KEY_W_LOG2];

    // Ids past the last key match nothing, so they fall through as idle.
    always_comb begin
        sel_pressed = 1'b0;
        sel_fading  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_id == KID_W'(k)) begin
                sel_pressed = pressed[k];
                sel_fading  = !pressed[k] && (cnt[k] != '0);
            end
        end
    end

    assign is_key   = in_y > CW'(KEY_TOP);
    assign is_div   = (in_y == CW'(KEY_TOP - 2)) || (in_y == CW'(KEY_TOP - 1));
    assign is_vline = is_key && (in_x[KEY_W_LOG2-1:0] < KEY_W_LOG2'(LINE_W));

    always_comb begin
        base = in_color;
        if (in_finger)
            base = 9'b111000000;
        else if (is_key && sel_pressed)
            base = 9'b111111100;

        filter = 9'b000000000;
        if (is_div)
            filter = 9'b000100000;
        else if (is_key && sel_pressed)
            filter = 9'b100100000;
        else if (is_key && sel_fading)
            filter = 9'b010010000;
        else if (is_key)
            filter = 9'b110110110;
    end

    function automatic logic [2:0] sat3(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[3] ? 3'd7 : s[2:0];
    endfunction

    logic       s1_valid;
    logic [8:0] s1_base;
    logic [8:0] s1_filter;
    logic       s1_vline;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_base   <= '0;
            s1_filter <= '0;
            s1_vline  <= 1'b0;
            out_valid <= 1'b0;
            out_color <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_base   <= base;
            s1_filter <= filter;
            s1_vline  <= is_vline;
            out_valid <= s1_valid;
            out_color <= s1_vline ? 9'b000000000 :
                         {sat3(s1_base[8:6], s1_filter[8:6]),
                          sat3(s1_base[5:3], s1_filter[5:3]),
                          sat3(s1_base[2:0], s1_filter[2:0])};
        end
    end
endmodule

// File: tb/tb_key_overlay.sv
// tb/tb_key_overlay.sv - randomized and directed bench for key_overlay with a behavioural model
module tb_key_overlay;
    localparam int NUM_KEYS   = 40;
    localparam int KEY_W_LOG2 = 4;
    localparam int KEY_W      = 16;
    localparam int KEY_TOP    = 320;
    localparam int LINE_W     = 2;
    localparam int HOLD       = 8;
    localparam int CW         = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                frame_start;
    logic [NUM_KEYS-1:0] key_down;
    logic                in_valid;
    logic [CW-1:0]       in_x;
    logic [CW-1:0]       in_y;
    logic [8:0]          in_color;
    logic                in_finger;
    logic                out_valid;
    logic [8:0]          out_color;

    int n_pass  = 0;
    int n_total = 0;

    bit         m_pressed [NUM_KEYS];
    int         m_cnt     [NUM_KEYS];
    bit         pend_v = 1'b0;
    logic [8:0] pend_c = '0;

    key_overlay #(
        .NUM_KEYS(NUM_KEYS), .KEY_W_LOG2(KEY_W_LOG2), .KEY_TOP(KEY_TOP),
        .LINE_W(LINE_W), .HOLD_FRAMES(HOLD), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .key_down(key_down),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_color(in_color),
        .in_finger(in_finger), .out_valid(out_valid), .out_color(out_color)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < NUM_KEYS; k++) begin
            m_pressed[k] = 1'b0;
            m_cnt[k]     = 0;
        end
        pend_v = 1'b0;
    endtask

    task automatic model_frame(input logic [NUM_KEYS-1:0] kd);
        for (int k = 0; k < NUM_KEYS; k++) begin
            m_pressed[k] = kd[k];
            if (kd[k]) m_cnt[k] = HOLD;
            else if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
        end
    endtask

    function automatic logic [8:0] model_color(int x, int y, logic [8:0] c, bit f);
        int kid, bs, fs, s;
        bit key, div, vl, p, fd;
        logic [8:0] base, filt, o;
        kid = x / KEY_W;
        key = y > KEY_TOP;
        div = (y == KEY_TOP - 2) || (y == KEY_TOP - 1);
        vl  = key && ((x % KEY_W) < LINE_W);
        p = 1'b0;
        fd = 1'b0;
        if (key && kid < NUM_KEYS) begin
            p  = m_pressed[kid];
            fd = !m_pressed[kid] && m_cnt[kid] != 0;
        end
        base = f ? 9'b111000000 : (p ? 9'b111111100 : c);
        if (div)     filt = 9'b000100000;
        else if (!key) filt = 9'b000000000;
        else if (p)  filt = 9'b100100000;
        else if (fd) filt = 9'b010010000;
        else         filt = 9'b110110110;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            bs = int'(base[3*ch +: 3]);
            fs = int'(filt[3*ch +: 3]);
            s  = (bs + fs > 7) ? 7 : bs + fs;
            if (vl) s = 0;
            o[3*ch +: 3] = 3'(s);
        end
        return o;
    endfunction

    task automatic set_px(input bit v, input int x, input int y, input logic [8:0] c,
                          input bit f, input bit fs);
        in_valid    = v;
        in_x        = CW'(x);
        in_y        = CW'(y);
        in_color    = c;
        in_finger   = f;
        frame_start = fs;
    endtask

    // One clock: returns DUT outputs and the model's expectation for the pixel two cycles back.
    task automatic step(output bit ov, output logic [8:0] oc, output bit ev, output logic [8:0] ec);
        bit cv;
        logic [8:0] cc;
        cv = in_valid;
        cc = model_color(int'(in_x), int'(in_y), in_color, in_finger);
        if (frame_start) model_frame(key_down);
        @(posedge clk);
        #1;
        ov = out_valid;
        oc = out_color;
        ev = pend_v;
        ec = pend_c;
        pend_v = cv;
        pend_c = cc;
    endtask

    task automatic px(input int x, input int y, input logic [8:0] c, input bit f, input bit fs,
                      output bit ov, output logic [8:0] oc);
        bit ev;
        logic [8:0] ec;
        set_px(1'b1, x, y, c, f, fs);
        step(ov, oc, ev, ec);
        set_px(1'b0, 0, 0, 9'd0, 1'b0, 1'b0);
        step(ov, oc, ev, ec);
    endtask

    task automatic frame_pulse();
        bit ov, ev;
        logic [8:0] oc, ec;
        set_px(1'b0, 0, 0, 9'd0, 1'b0, 1'b1);
        step(ov, oc, ev, ec);
        set_px(1'b0, 0, 0, 9'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_down = '0;
        set_px(1'b0, 0, 0, 9'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++;
        if (out_color !== 9'd0) $display("FAIL reset_color: got %b want 0", out_color); else n_pass++;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_idle();
        bit ov;
        logic [8:0] oc;
        key_down = '1;
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (ov !== 1'b1) $display("FAIL idle_valid: got %b want 1", ov); else n_pass++;
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL idle_fill: got %b want 110110110", oc); else n_pass++;
        px(16, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'd0) $display("FAIL vline_x16: got %b want 0", oc); else n_pass++;
        px(17, 400, 9'b111111111, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'd0) $display("FAIL vline_x17: got %b want 0", oc); else n_pass++;
        px(18, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL vline_x18: got %b want 110110110", oc); else n_pass++;
    endtask

    task automatic test_press();
        bit ov;
        logic [8:0] oc;
        key_down = NUM_KEYS'(2);
        px(20, 400, 9'd0, 1'b0, 1'b1, ov, oc);
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL press_same_cycle: got %b want 110110110", oc); else n_pass++;
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b111111100) $display("FAIL press_lit: got %b want 111111100", oc); else n_pass++;
        key_down = '0;
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b111111100) $display("FAIL press_ignore_midframe: got %b want 111111100", oc); else n_pass++;
    endtask

    task automatic test_fade();
        bit ov;
        logic [8:0] oc;
        key_down = '0;
        frame_pulse();
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b010010000) $display("FAIL fade_first: got %b want 010010000", oc); else n_pass++;
        repeat (HOLD - 2) frame_pulse();
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b010010000) $display("FAIL fade_last: got %b want 010010000", oc); else n_pass++;
        frame_pulse();
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL fade_done: got %b want 110110110", oc); else n_pass++;
        frame_pulse();
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL fade_no_wrap: got %b want 110110110", oc); else n_pass++;
    endtask

    task automatic test_divider_boundary();
        bit ov;
        logic [8:0] oc;
        px(5, 318, 9'b001001001, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b001101001) $display("FAIL divider_318: got %b want 001101001", oc); else n_pass++;
        px(5, 319, 9'b001001001, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b001101001) $display("FAIL divider_319: got %b want 001101001", oc); else n_pass++;
        px(5, 320, 9'b001001001, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b001001001) $display("FAIL plain_320: got %b want 001001001", oc); else n_pass++;
        px(5, 317, 9'b011010001, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b011010001) $display("FAIL plain_317: got %b want 011010001", oc); else n_pass++;
        key_down = '1;
        frame_pulse();
        px(NUM_KEYS * KEY_W + 5, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL out_of_range_idle: got %b want 110110110", oc); else n_pass++;
        px(5, 321, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b111111100) $display("FAIL key0_first_row: got %b want 111111100", oc); else n_pass++;
    endtask

    task automatic test_finger();
        bit ov;
        logic [8:0] oc;
        px(100, 10, 9'b010101010, 1'b1, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b111000000) $display("FAIL finger_canvas: got %b want 111000000", oc); else n_pass++;
        px(20, 400, 9'd0, 1'b1, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b111100000) $display("FAIL finger_pressed: got %b want 111100000", oc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ov, ev;
        logic [8:0] oc, ec;
        int y;
        for (int i = 0; i < 600; i++) begin
            key_down = NUM_KEYS'({$urandom(), $urandom()});
            y = ($urandom_range(0, 3) == 0) ? 316 + int'($urandom_range(0, 6)) : int'($urandom_range(0, 479));
            set_px($urandom_range(0, 3) != 0, int'($urandom_range(0, 700)), y, 9'($urandom()),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            step(ov, oc, ev, ec);
            n_total++;
            if (ov !== ev) $display("FAIL stream_valid[%0d]: got %b want %b", i, ov, ev); else n_pass++;
            if (ev) begin
                n_total++;
                if (oc !== ec) $display("FAIL stream_color[%0d]: got %b want %b", i, oc, ec); else n_pass++;
            end
        end
        set_px(1'b0, 0, 0, 9'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(ov, oc, ev, ec);
            n_total++;
            if (ov !== ev) $display("FAIL stream_drain_valid: got %b want %b", ov, ev); else n_pass++;
            if (ev) begin
                n_total++;
                if (oc !== ec) $display("FAIL stream_drain_color: got %b want %b", oc, ec); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        bit ov, ev;
        logic [8:0] oc, ec;
        key_down = '1;
        frame_pulse();
        set_px(1'b1, 20, 400, 9'd0, 1'b0, 1'b0);
        step(ov, oc, ev, ec);
        step(ov, oc, ev, ec);
        n_total++;
        if (ov !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", ov); else n_pass++;
        set_px(1'b0, 0, 0, 9'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++;
        if (out_color !== 9'd0) $display("FAIL async_reset_color: got %b want 0", out_color); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        step(ov, oc, ev, ec);
        n_total++;
        if (ov !== 1'b0) $display("FAIL flushed_inflight: got %b want 0", ov); else n_pass++;
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b110110110) $display("FAIL post_reset_idle: got %b want 110110110", oc); else n_pass++;
        frame_pulse();
        px(20, 400, 9'd0, 1'b0, 1'b0, ov, oc);
        n_total++;
        if (oc !== 9'b111111100) $display("FAIL post_reset_load: got %b want 111111100", oc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_fade();
        test_divider_boundary();
        test_finger();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
